// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the elastic pipeline stage chain.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int MAX_PIPE_DEPTH  = 8;
  localparam int STALL_CNT_WIDTH = 16;

  // Bits needed to hold a count of 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake and observation bundle between a producer/consumer and the stage chain.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both ends; flush_mask and stage taps are side channels.
interface pipe_stage_chain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
);

  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_ready;
  logic [DEPTH-1:0]            flush_mask;
  logic [DEPTH-1:0]            stage_valid;
  logic [DEPTH*DATA_WIDTH-1:0] stage_data;

  // The side that feeds tokens, consumes results and drives flushes.
  modport master (
    output in_valid, in_data, out_ready, flush_mask,
    input  in_ready, out_valid, out_data, stage_valid, stage_data
  );

  // The stage chain itself.
  modport slave (
    input  in_valid, in_data, out_ready, flush_mask,
    output in_ready, out_valid, out_data, stage_valid, stage_data
  );

endinterface

// File: rtl/pipe_stage_chain_stage.sv
// One elastic pipeline stage: valid/data register, flush-qualified valid and local ready.
// Latency: 1 cycle from up_valid to v.
// Backpressure: rdy drops only when holding a live token and the downstream is not ready.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  flush,
  input  logic                  down_rdy,
  output logic                  v,
  output logic                  ev,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  rdy
);

  // A flushed token behaves as a bubble in the same cycle, so it never blocks.
  assign ev  = v & ~flush;
  assign rdy = down_rdy | ~ev;

  // Load from upstream when free; data only moves with a valid token so an idle
  // stage keeps its last payload; a blocked stage keeps its (live) token.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_DATA;
    end else if (rdy) begin
      v <= up_valid;
      if (up_valid) begin
        d <= up_data;
      end
    end else begin
      v <= ev;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH stages with bubble collapsing, per-stage flush and stage taps.
// Latency: DEPTH-1 cycles after the accepting edge when unstalled; 1 token/cycle throughput.
// Backpressure: ready ripples back combinationally; empty stages keep accepting while output stalls.
// Optional statistics (occupancy, stall_cycles) are built when PIPE_STAGE_CHAIN_STATS_EN is defined.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  pipe_stage_chain_if.slave               bus
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  ,
  output logic [occ_width(DEPTH)-1:0]     occupancy,
  output logic [STALL_CNT_WIDTH-1:0]      stall_cycles
`endif
);

  if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $fatal(1, "pipe_stage_chain: DEPTH must be within 1..8");
  end

  logic [DEPTH-1:0]                 v;
  logic [DEPTH-1:0]                 ev;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] d;

  // Stage 0 is the youngest; each stage's ready is a separate per-block net so the
  // back-propagating chain is a plain sequence of gates, not a self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  up_valid;
    logic [DATA_WIDTH-1:0] up_data;
    logic                  down_rdy;
    logic                  rdy;

    if (i == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_body
      assign up_valid = ev[i-1];
      assign up_data  = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign down_rdy = bus.out_ready;
    end else begin : g_link
      assign down_rdy = g_stage[i+1].rdy;
    end

    pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .flush    (bus.flush_mask[i]),
      .down_rdy (down_rdy),
      .v        (v[i]),
      .ev       (ev[i]),
      .d        (d[i]),
      .rdy      (rdy)
    );
  end

  assign bus.in_ready    = g_stage[0].rdy;
  assign bus.out_valid   = ev[DEPTH-1];
  assign bus.out_data    = d[DEPTH-1];
  assign bus.stage_valid = ev;
  assign bus.stage_data  = d;

`ifdef PIPE_STAGE_CHAIN_STATS_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_sum;

  // Count raw (unflushed-qualified) stage valids.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(v[i]);
    end
  end

  // Occupancy is a registered copy of the current valid count.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_sum;
    end
  end

  // Saturating count of cycles where a token waits on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.out_valid && !bus.out_ready &&
                 (stall_cycles != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
    end
  end
`else
  logic unused_v;
  assign unused_v = ^v;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (DEPTH=3, DATA_WIDTH=16) with a slot-level token model.
// Latency: n/a.
// Backpressure: exercised via directed stalls and randomized out_ready.
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  localparam int              DW      = 16;
  localparam int              D       = 3;
  localparam logic [DW-1:0]   RST_VAL = 16'hDEAD;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

`ifdef PIPE_STAGE_CHAIN_STATS_EN
  logic [occ_width(D)-1:0] occupancy;
  logic [15:0]             stall_cycles;
`endif

  pipe_stage_chain #(
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .RESET_DATA (RST_VAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    ,
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
`endif
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            slot [D];          // token id held by each stage, -1 when empty
  logic [DW-1:0] tok_data [$];      // payload of every accepted token, by id
  bit            dropped [int];     // ids killed by flush
  exp_t          exp_q [$];
  int            m_stall = 0;
  int            m_occ   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, compare against the model, advance the model at the edge.
  task automatic step(input logic iv, input logic [DW-1:0] idat, input logic ordy,
                      input logic [D-1:0] fm, output bit acc);
    bit            m_ev [D];
    bit            m_rdy [D];
    bit            r;
    int            nslot [D];
    int            nid;
    int            occ_now;
    logic [D-1:0]  exp_sv;
    bus.in_valid   = iv;
    bus.in_data    = idat;
    bus.out_ready  = ordy;
    bus.flush_mask = fm;
    #1;
    occ_now = 0;
    for (int i = 0; i < D; i++) begin
      m_ev[i]   = (slot[i] >= 0) && !fm[i];
      exp_sv[i] = m_ev[i];
      if (slot[i] >= 0) occ_now++;
    end
    r = ordy;
    for (int i = D - 1; i >= 0; i--) begin
      m_rdy[i] = r || !m_ev[i];
      r        = m_rdy[i];
    end
    chk("in_ready", 64'(bus.in_ready), 64'(m_rdy[0]));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ev[D-1]));
    chk("stage_valid", 64'(bus.stage_valid), 64'(exp_sv));
    for (int i = 0; i < D; i++) begin
      if (m_ev[i]) chk("stage_data", 64'(bus.stage_data[i*DW +: DW]), 64'(tok_data[slot[i]]));
    end
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("occupancy", 64'(occupancy), 64'(m_occ));
`endif
    for (int i = 0; i < D; i++) begin
      if (slot[i] >= 0 && fm[i]) dropped[slot[i]] = 1'b1;
    end
    acc = iv && bus.in_ready;
    nid = -1;
    if (iv && m_rdy[0]) begin
      nid = tok_data.size();
      tok_data.push_back(idat);
      exp_q.push_back('{nid, idat});
    end
    if (m_ev[D-1] && !ordy && m_stall != 32'hFFFF) m_stall++;
    @(posedge clk);
    for (int i = D - 1; i >= 0; i--) begin
      if (!m_rdy[i])   nslot[i] = slot[i];
      else if (i == 0) nslot[i] = nid;
      else             nslot[i] = m_ev[i-1] ? slot[i-1] : -1;
    end
    slot  = nslot;
    m_occ = occ_now;
    #2;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.flush_mask = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < D; i++) slot[i] = -1;
    exp_q.delete();
    m_stall = 0;
    m_occ   = 0;
    #1;
    chk("rst_stage_valid", 64'(bus.stage_valid), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_stage_data", 64'(bus.stage_data), 64'({D{RST_VAL}}));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef PIPE_STAGE_CHAIN_STATS_EN
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
`endif
  endtask

  // Monitor: every output transfer must match the oldest surviving accepted token.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        while (exp_q.size() > 0 && dropped.exists(exp_q[0].id)) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard: got token 0x%0h, want no token", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin : stim
    bit acc;
    int k;
    int left;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.flush_mask = '0;
    for (int i = 0; i < D; i++) slot[i] = -1;
    do_reset();

    // Stream 1..5 with the consumer always ready.
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b1, '0, acc);
    repeat (4) step(1'b0, '0, 1'b1, '0, acc);

    // Backpressure: only three tokens fit while the output is stalled.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, DW'(16'hA0 + k), 1'b0, '0, acc);
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'(3));
    for (int c = 0; c < 12; c++) begin
      step(k < 5, DW'(16'hA0 + k), 1'b1, '0, acc);
      if (acc) k++;
    end
    chk("bp_total", 64'(k), 64'(5));

    // Bubble collapse: two tokens with a gap pack into the two oldest stages.
    do_reset();
    step(1'b1, 16'h0011, 1'b0, '0, acc);
    step(1'b0, '0,       1'b0, '0, acc);
    step(1'b1, 16'h0022, 1'b0, '0, acc);
    step(1'b0, '0,       1'b0, '0, acc);
    chk("bubble_stage_valid", 64'(bus.stage_valid), 64'(3'b110));
    repeat (4) step(1'b0, '0, 1'b1, '0, acc);

    // Flush the middle stage while draining: 0x22 must never reach the output.
    do_reset();
    step(1'b1, 16'h0033, 1'b0, '0, acc);
    step(1'b1, 16'h0022, 1'b0, '0, acc);
    step(1'b1, 16'h0011, 1'b0, '0, acc);
    chk("flush_setup", 64'(bus.stage_data), 64'(48'h0033_0022_0011));
    step(1'b0, '0, 1'b1, 3'b010, acc);
    repeat (4) step(1'b0, '0, 1'b1, '0, acc);

    // Reset while full.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'hC0 + i), 1'b0, '0, acc);
    do_reset();

`ifdef PIPE_STAGE_CHAIN_STATS_EN
    for (int i = 0; i < 3; i++) step(1'b1, DW'(16'hE0 + i), 1'b0, '0, acc);
    repeat (20) step(1'b0, '0, 1'b0, '0, acc);
    chk("stall_20", 64'(stall_cycles), 64'(20));
    chk("occupancy_full", 64'(occupancy), 64'(3));
    repeat (65530) step(1'b0, '0, 1'b0, '0, acc);
    chk("stall_saturate", 64'(stall_cycles), 64'(16'hFFFF));
    do_reset();
`endif

    // Randomized traffic with occasional flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
             ($urandom_range(0, 7) == 0) ? D'($urandom_range(1, 7)) : '0, acc);
      end
    end
    repeat (D + 3) step(1'b0, '0, 1'b1, '0, acc);

    left = 0;
    foreach (exp_q[i]) if (!dropped.exists(exp_q[i].id)) left++;
    chk("scoreboard_drained", 64'(left), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
